// File: rtl/usrdemux_pkg.sv
// usrdemux_pkg
// Shared constants for the usrdemux slice: default data width, default
// per-output buffer depth, and the width of a 0..DEPTH occupancy count.
package usrdemux_pkg;

    localparam int WIDTH_DEFAULT = 64;
    localparam int DEPTH_DEFAULT = 2;

    // Occupancy counts must reach DEPTH itself, hence DEPTH+1 codes.
    localparam int COUNT_W_DEFAULT = $clog2(DEPTH_DEFAULT + 1);

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width; a depth of 1 would give $clog2 == 0, so floor at 1.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/usrdemux_fifo.sv
// usrdemux_fifo
// Single-clock FIFO of DEPTH entries feeding one demux output.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset (clears count and pointers)
//   push   - write din this cycle (ignored when full)
//   pop    - remove the head entry this cycle (ignored when empty)
//   din    - write data
//   dout   - head entry, forced to 0 while the FIFO is empty
//   valid  - FIFO not empty
//   full   - count == DEPTH
//   count  - current occupancy, 0..DEPTH
module usrdemux_fifo
    import usrdemux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int CNT_W = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             do_push, do_pop;

    assign valid   = (count_reg != '0);
    assign full    = (count_reg == FULL_CNT);
    assign count   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && valid;

    // The head must be visible in the same cycle it becomes valid, so the
    // read is a plain array index. Gating with valid keeps dout at 0 while
    // empty, including immediately after an asynchronous reset.
    assign dout = valid ? mem[rd_ptr_reg] : '0;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop)
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            count_reg <= count_next;
        end
    end

    // Storage carries no reset; stale contents are never visible because
    // dout is masked whenever the count is zero.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/usrdemux.sv
// usrdemux
// 1-to-2 valid/ready demultiplexer with an independent FIFO per output.
// Ports:
//   clk, rst                      - clock and asynchronous active-high reset
//   usrdemux_sel                  - 1 routes the input beat to output 1, 0 to output 2
//   usrdemux_i_valid / _i_ready   - input handshake; ready reflects only the
//                                   selected buffer's fullness
//   usrdemux_i                    - input data
//   usrdemux_o1_valid/_o1_ready/usrdemux_o1 - output 1 handshake and data
//   usrdemux_o2_valid/_o2_ready/usrdemux_o2 - output 2 handshake and data
module usrdemux
    import usrdemux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT   // legal range 2..16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             usrdemux_sel,
    input  logic             usrdemux_i_valid,
    output logic             usrdemux_i_ready,
    input  logic [WIDTH-1:0] usrdemux_i,
    output logic             usrdemux_o1_valid,
    input  logic             usrdemux_o1_ready,
    output logic [WIDTH-1:0] usrdemux_o1,
    output logic             usrdemux_o2_valid,
    input  logic             usrdemux_o2_ready,
    output logic [WIDTH-1:0] usrdemux_o2
);

    // Index 0 serves output 1, index 1 serves output 2.
    logic [1:0]       route, push, pop, valid, full, o_ready;
    logic [WIDTH-1:0] dout [2];

    assign route   = {~usrdemux_sel, usrdemux_sel};
    assign o_ready = {usrdemux_o2_ready, usrdemux_o1_ready};

    // Ready looks only at the buffer the current beat is steered to, so a
    // full output never stalls traffic bound for the other one. A pop on a
    // full buffer does not open it up in the same cycle.
    assign usrdemux_i_ready = usrdemux_sel ? ~full[0] : ~full[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_out
            assign push[gi] = usrdemux_i_valid & usrdemux_i_ready & route[gi];
            assign pop[gi]  = valid[gi] & o_ready[gi];

            usrdemux_fifo #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (push[gi]),
                .pop   (pop[gi]),
                .din   (usrdemux_i),
                .dout  (dout[gi]),
                .valid (valid[gi]),
                .full  (full[gi]),
                .count ()
            );
        end
    endgenerate

    assign usrdemux_o1_valid = valid[0];
    assign usrdemux_o2_valid = valid[1];
    assign usrdemux_o1       = dout[0];
    assign usrdemux_o2       = dout[1];

endmodule

// File: doc/usrdemux.md
USRDEMUX -- requirements
Module: usrdemux

Interface
REQ-001 Parameter WIDTH, default 64: data width of the input and each output.
REQ-002 Parameter DEPTH, default 2: per-output buffer depth in entries; legal range 2..16.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 usrdemux_sel  input  1  route select for the current input beat; 1 routes to output 1, 0 routes to output 2.
REQ-006 usrdemux_i_valid  input  1  input beat valid.
REQ-007 usrdemux_i_ready  output  1  input beat accepted when high together with usrdemux_i_valid.
REQ-008 usrdemux_i  input  WIDTH  input data.
REQ-009 usrdemux_o1_valid / usrdemux_o2_valid  output  1  output-side beat valid, one per output.
REQ-010 usrdemux_o1_ready / usrdemux_o2_ready  input  1  downstream ready, one per output.
REQ-011 usrdemux_o1 / usrdemux_o2  output  WIDTH  output data, one per output.

Function
REQ-012 A beat transfers on the input when usrdemux_i_valid and usrdemux_i_ready are both high at a rising edge.
REQ-013 usrdemux_i_ready is combinational: usrdemux_sel ? !full1 : !full2; it does not depend on usrdemux_i_valid or on any downstream ready.
REQ-014 A transferred beat is written to the buffer of the output selected by usrdemux_sel in that same cycle; the other buffer is unaffected.
REQ-015 Each buffer is a FIFO of DEPTH entries with a count 0..DEPTH; full = (count == DEPTH), empty = (count == 0).
REQ-016 usrdemux_oN_valid is high exactly when buffer N is not empty; usrdemux_oN presents the head entry.
REQ-017 A beat leaves buffer N when usrdemux_oN_valid and usrdemux_oN_ready are both high at a rising edge.
REQ-018 Latency: a beat accepted at edge k into an empty buffer drives usrdemux_oN_valid high after edge k; there is no same-cycle combinational pass-through.
REQ-019 Simultaneous push and pop on the same buffer leaves its count unchanged and keeps FIFO order; this is legal at any count below DEPTH.
REQ-020 Full buffer with a pop in the same cycle: input stays not-ready for that buffer in that cycle (REQ-013); no bubble-free push-through.
REQ-021 While usrdemux_oN_valid is high and usrdemux_oN_ready is low, usrdemux_oN and usrdemux_oN_valid hold stable.
REQ-022 Read/write pointers wrap modulo DEPTH; order per output is strictly preserved across wrap.
REQ-023 No ordering guarantee exists between beats routed to different outputs; each output drains independently.
REQ-024 A full output never blocks beats routed to the other output.

Reset
REQ-025 While rst is high: both counts and pointers are 0, usrdemux_o1_valid = usrdemux_o2_valid = 0, and usrdemux_o1 = usrdemux_o2 = 0.
REQ-026 Reset asserted mid-operation discards all buffered beats immediately; no beat is presented after reset release until a new one is accepted.
REQ-027 usrdemux_i_ready reads 1 during and after reset, because both buffers are empty.

Structure
REQ-028 Package usrdemux_pkg holds the WIDTH and DEPTH defaults and the count-width constant $clog2(DEPTH+1).
REQ-029 One sub-module, usrdemux_fifo (clk, rst, push, pop, din, dout, valid, full, count), is instantiated twice.
REQ-030 The top level contains only the select/ready steering logic and the two FIFO instances.

Verification
REQ-031 Reset, then send 3 beats 0x11,0x22,0x33 with sel=1 and o1_ready=1 -> the same order appears on o1 starting one cycle after each accept; o2_valid stays 0.
REQ-032 DEPTH=2, o2_ready=0, send 3 beats with sel=0 -> i_ready drops after 2 accepts; the third beat is accepted only in the cycle after o2_ready=1 pops 1 entry.
REQ-033 Buffer 2 full, send sel=1 beat 0xAA -> accepted immediately and appears on o1 while o2 holds its head stable.
REQ-034 Continuous push and pop on o1 for 10 beats with count=1 -> count stays 1, with no loss or reorder across pointer wrap.
REQ-035 Assert rst with 2 beats buffered in each output -> both valids are 0 at once, data outputs are 0, and i_ready=1 after release.
REQ-036 Randomized sel, valid and ready for 10k cycles against a scoreboard with one queue per output -> zero mismatches, and output data is stable during every stall.
